// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes,
// channel FSM states and the register address decoder.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_HAVE_A = 2'd1,
      WR_HAVE_D = 2'd2,
      WR_RESP   = 2'd3
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_t;

   typedef struct packed {
      logic       hit;
      logic [7:0] idx;
   } dec_t;

   function automatic dec_t addr_decode(
      input logic [31:0] addr,
      input logic [31:0] base,
      input int unsigned nregs
   );
      logic [31:0] off;
      off = addr - base;
      addr_decode.hit = (addr >= base) && ((off >> 2) < nregs);
      addr_decode.idx = 8'(off >> 2);
   endfunction

endpackage

// File: rtl/axi4_lite_slave_regs_regfile.sv
// Register array with byte-strobed write, combinational read port
// and flattened parallel output of every register.
module axi4_lite_slave_regfile
   import axi4_lite_pkg::*;
#(
   parameter int          NUM_REGS    = 16,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    i_we,
   input  logic [7:0]              i_widx,
   input  logic [31:0]             i_wdata,
   input  logic [3:0]              i_wstrb,
   input  logic [7:0]              i_ridx,
   output logic [31:0]             o_rdata,
   output logic [NUM_REGS*32-1:0]  o_regs
);

   logic [31:0] r_regs [NUM_REGS];

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int k = 0; k < NUM_REGS; k++)
            r_regs[k] <= RESET_VALUE;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (i_we && (i_widx == 8'(k))) begin
               for (int b = 0; b < 4; b++)
                  if (i_wstrb[b])
                     r_regs[k][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      o_rdata = 32'h0;
      for (int k = 0; k < NUM_REGS; k++)
         if (i_ridx == 8'(k))
            o_rdata = r_regs[k];
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign o_regs[32*g +: 32] = r_regs[g];
   end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register slave with independent write and read FSMs.
// Define AXI4_LITE_SLAVE_SLVERR_EN to answer out-of-range with SLVERR.
module axi4_lite_slave_regs
   import axi4_lite_pkg::*;
#(
   parameter int          NUM_REGS    = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   input  logic [31:0]            S_AXI_AWADDR,
   input  logic [3:0]             S_AXI_AWCACHE,
   input  logic [2:0]             S_AXI_AWPROT,
   input  logic                   S_AXI_AWVALID,
   output logic                   S_AXI_AWREADY,
   input  logic [31:0]            S_AXI_WDATA,
   input  logic [3:0]             S_AXI_WSTRB,
   input  logic                   S_AXI_WVALID,
   output logic                   S_AXI_WREADY,
   output logic [1:0]             S_AXI_BRESP,
   output logic                   S_AXI_BVALID,
   input  logic                   S_AXI_BREADY,
   input  logic [31:0]            S_AXI_ARADDR,
   input  logic [3:0]             S_AXI_ARCACHE,
   input  logic [2:0]             S_AXI_ARPROT,
   input  logic                   S_AXI_ARVALID,
   output logic                   S_AXI_ARREADY,
   output logic [31:0]            S_AXI_RDATA,
   output logic [1:0]             S_AXI_RRESP,
   output logic                   S_AXI_RVALID,
   input  logic                   S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0] regs_o
);

`ifdef AXI4_LITE_SLAVE_SLVERR_EN
   localparam axi_resp_t ERR_RESP = SLVERR;
`else
   localparam axi_resp_t ERR_RESP = OKAY;
`endif

   wr_state_t   r_wr_state, w_wr_next;
   logic        r_awready, r_wready, r_bvalid;
   axi_resp_t   r_bresp;
   logic [31:0] r_awaddr, r_wdata;
   logic [3:0]  r_wstrb;
   logic        w_aw_hs, w_w_hs, w_we;
   logic [31:0] w_waddr, w_wdat;
   logic [3:0]  w_wstb;
   dec_t        w_wdec, w_rdec;

   rd_state_t   r_rd_state;
   logic        r_arready, r_rvalid;
   logic [31:0] r_rdata;
   axi_resp_t   r_rresp;
   logic        w_ar_hs;
   logic [31:0] w_rf_rdata;
   logic        w_unused;

   assign w_unused = ^{S_AXI_AWCACHE, S_AXI_AWPROT,
                       S_AXI_ARCACHE, S_AXI_ARPROT};

   assign w_aw_hs = S_AXI_AWVALID && r_awready;
   assign w_w_hs  = S_AXI_WVALID && r_wready;
   assign w_ar_hs = S_AXI_ARVALID && r_arready;

   always_comb begin
      w_wr_next = r_wr_state;
      w_we      = 1'b0;
      unique case (r_wr_state)
         WR_IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               w_we      = 1'b1;
               w_wr_next = WR_RESP;
            end else if (w_aw_hs) begin
               w_wr_next = WR_HAVE_A;
            end else if (w_w_hs) begin
               w_wr_next = WR_HAVE_D;
            end
         end
         WR_HAVE_A: begin
            if (w_w_hs) begin
               w_we      = 1'b1;
               w_wr_next = WR_RESP;
            end
         end
         WR_HAVE_D: begin
            if (w_aw_hs) begin
               w_we      = 1'b1;
               w_wr_next = WR_RESP;
            end
         end
         WR_RESP: begin
            if (S_AXI_BREADY)
               w_wr_next = WR_IDLE;
         end
         default: w_wr_next = WR_IDLE;
      endcase
   end

   // Whichever half arrived first comes from its latch.
   assign w_waddr = (r_wr_state == WR_HAVE_A) ? r_awaddr : S_AXI_AWADDR;
   assign w_wdat  = (r_wr_state == WR_HAVE_D) ? r_wdata  : S_AXI_WDATA;
   assign w_wstb  = (r_wr_state == WR_HAVE_D) ? r_wstrb  : S_AXI_WSTRB;
   assign w_wdec  = addr_decode(w_waddr, BASE_ADDR, NUM_REGS);
   assign w_rdec  = addr_decode(S_AXI_ARADDR, BASE_ADDR, NUM_REGS);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_wr_state <= WR_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= OKAY;
         r_awaddr   <= 32'h0;
         r_wdata    <= 32'h0;
         r_wstrb    <= 4'h0;
      end else begin
         r_wr_state <= w_wr_next;
         r_awready  <= (w_wr_next == WR_IDLE) || (w_wr_next == WR_HAVE_D);
         r_wready   <= (w_wr_next == WR_IDLE) || (w_wr_next == WR_HAVE_A);
         r_bvalid   <= (w_wr_next == WR_RESP);
         if ((r_wr_state == WR_IDLE) && w_aw_hs)
            r_awaddr <= S_AXI_AWADDR;
         if ((r_wr_state == WR_IDLE) && w_w_hs) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
         end
         if (w_we)
            r_bresp <= w_wdec.hit ? OKAY : ERR_RESP;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_rd_state <= RD_IDLE;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= 32'h0;
         r_rresp    <= OKAY;
      end else if (r_rd_state == RD_IDLE) begin
         if (w_ar_hs) begin
            r_rd_state <= RD_DATA;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_rdec.hit ? w_rf_rdata : 32'h0;
            r_rresp    <= w_rdec.hit ? OKAY : ERR_RESP;
         end else begin
            r_arready  <= 1'b1;
         end
      end else if (S_AXI_RREADY) begin
         r_rd_state <= RD_IDLE;
         r_rvalid   <= 1'b0;
         r_arready  <= 1'b1;
      end
   end

   axi4_lite_slave_regfile #(
      .NUM_REGS    (NUM_REGS),
      .RESET_VALUE (RESET_VALUE)
   ) u_regfile (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .i_we    (w_we && w_wdec.hit),
      .i_widx  (w_wdec.idx),
      .i_wdata (w_wdat),
      .i_wstrb (w_wstb),
      .i_ridx  (w_rdec.idx),
      .o_rdata (w_rf_rdata),
      .o_regs  (regs_o)
   );

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

Synthesizable AXI4-Lite responder exposing a bank of 32-bit read/write registers. It terminates the transactions issued by `axi4_lite_master_bfm` and gives benches and real designs a small, cycle-exact register target. Write and read channels are independent state machines. Every register value is also driven out in parallel for use by surrounding logic.

## Interface
Parameters:
- `NUM_REGS`, default 16: number of 32-bit registers, 1..256.
- `BASE_ADDR`, default 32'h0000_0000: byte address of register 0; must be aligned to `NUM_REGS*4` rounded up to a power of two.
- `RESET_VALUE`, default 32'h0000_0000: reset content of every register.

Ports (one clock; reset is asynchronous and active-low; named as in the codebase):
- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESETN`  in  1  asynchronous active-low reset.
- `S_AXI_AWADDR` in 32 / `S_AXI_AWCACHE` in 4 / `S_AXI_AWPROT` in 3: write address (cache and prot ignored).
- `S_AXI_AWVALID` in 1 / `S_AXI_AWREADY` out 1: write address handshake.
- `S_AXI_WDATA` in 32 / `S_AXI_WSTRB` in 4: write data and byte strobes.
- `S_AXI_WVALID` in 1 / `S_AXI_WREADY` out 1: write data handshake.
- `S_AXI_BRESP` out 2 / `S_AXI_BVALID` out 1 / `S_AXI_BREADY` in 1: write response.
- `S_AXI_ARADDR` in 32 / `S_AXI_ARCACHE` in 4 / `S_AXI_ARPROT` in 3: read address (cache and prot ignored).
- `S_AXI_ARVALID` in 1 / `S_AXI_ARREADY` out 1: read address handshake.
- `S_AXI_RDATA` out 32 / `S_AXI_RRESP` out 2 / `S_AXI_RVALID` out 1 / `S_AXI_RREADY` in 1: read data.
- `regs_o`  out  `NUM_REGS*32`  register k occupies bits [32k+31:32k].

## Operation
- **Decode**
  - Index = `(addr - BASE_ADDR) >> 2`.
  - `addr[1:0]` is ignored.
  - In range when `addr >= BASE_ADDR` and index < `NUM_REGS`.
- **Write FSM**, states WR_IDLE, WR_HAVE_A, WR_HAVE_D, WR_RESP.
  - WR_IDLE: AWREADY=1, WREADY=1.
    - AW and W both handshake in the same cycle: commit the write, go to WR_RESP.
    - AW only: latch the address, go to WR_HAVE_A (AWREADY=0, WREADY=1).
    - W only: latch data and strobe, go to WR_HAVE_D (AWREADY=1, WREADY=0).
  - WR_HAVE_A / WR_HAVE_D: when the missing handshake completes, commit the write and go to WR_RESP.
  - WR_RESP: BVALID=1, both readies 0. BVALID and BRESP are held stable until BREADY; then return to WR_IDLE.
  - Commit: for each byte b with `WSTRB[b]`=1, `reg[idx][8b+7:8b] <= WDATA[8b+7:8b]`. Out-of-range writes change nothing.
- **Read FSM**, states RD_IDLE, RD_DATA.
  - RD_IDLE: ARREADY=1. On AR handshake, register RDATA and RRESP from the current register contents and go to RD_DATA.
  - RD_DATA: RVALID=1, ARREADY=0. RDATA and RRESP are held until RREADY; then return to RD_IDLE.
  - Out-of-range reads return RDATA=0.
- **Simultaneous events**
  - A read handshake in the same cycle as a write commit to the same register returns the pre-write value.
  - Read and write channels never stall each other.
- **Reset**: asynchronous and effective mid-transaction.
  - Both FSMs go to idle; all registers take `RESET_VALUE`.
  - In-flight transactions are dropped with no B or R beat.

## Timing
- Reset values: AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=2'b00, RRESP=2'b00, RDATA=0, `regs_o`={NUM_REGS{RESET_VALUE}}.
- All readies are registered. They rise at the first ACLK edge after ARESETN deasserts.
- Write latency: BVALID rises one cycle after the later of the AW and W handshakes. `regs_o` updates on that same edge.
- Read latency: RVALID rises one cycle after the AR handshake.
- Throughput: with BREADY and RREADY held high, at most one write per 2 cycles and one read per 2 cycles.
- VALID-to-READY combinational paths: none.

## Configuration
- `AXI4_LITE_SLAVE_SLVERR_EN` defined: out-of-range accesses return BRESP or RRESP = 2'b10 (SLVERR).
- Undefined: every response is 2'b00 (OKAY); out-of-range reads still return 0 and out-of-range writes are still discarded.

## Structure
- Shared package `axi4_lite_pkg`:
  - `axi_resp_t` (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
  - FSM enums `wr_state_t` and `rd_state_t`.
  - Address-decode function.
- Sub-module `axi4_lite_slave_regfile`: register array, byte-strobe write, combinational read port, `regs_o` flattening. Both FSMs stay in the top module.

## Test plan
- **Reset**: hold ARESETN=0 for 3 cycles, then release → all readies and valids 0 during reset; AWREADY, WREADY and ARREADY become 1 one edge later; register 0 reads 0.
- **Write/read**: write 0x0000_0004 = 0xDEAD_BEEF with WSTRB=4'hF, then read 0x0000_0004 → BRESP=OKAY one cycle after the handshakes, RDATA=0xDEAD_BEEF, and `regs_o[63:32]`=0xDEAD_BEEF.
- **Byte strobe / AW before W**: AW for 0x4 three cycles before W=0x1122_3344 with WSTRB=4'b0101 → register 1 = 0xDE22_BE44; AWREADY is low in between.
- **Backpressure**: BREADY=0 for 5 cycles after BVALID → BVALID, BRESP and all readies stay stable. Then pulse RREADY late on a read → RDATA is held.
- **Out of range**: write and read 0x0000_0040 with `NUM_REGS`=16 → no register changes and RDATA=0. Response is SLVERR with `AXI4_LITE_SLAVE_SLVERR_EN` defined, OKAY without it.
- **Collision and reset**:
  - AR for 0x8 on the cycle register 2 commits 0x5555_5555 (old value 0) → RDATA=0.
  - Drop ARESETN while BVALID=1 → BVALID falls immediately and register 2 returns to 0.
